// File: rtl/mm_seq_pkg.sv
// Shared definitions for the MATRIX_MUL sequencer: state encoding, element stride, opcode.
// Latency: n/a (package only).
// Backpressure: n/a.
package mm_seq_pkg;

    // 3-bit state encodings; the enum below reuses them so that encodings are visible to other tools.
    localparam logic [2:0] MM_IDLE = 3'd0;
    localparam logic [2:0] MM_RD_A = 3'd1;
    localparam logic [2:0] MM_WT_A = 3'd2;
    localparam logic [2:0] MM_RD_B = 3'd3;
    localparam logic [2:0] MM_WT_B = 3'd4;
    localparam logic [2:0] MM_MAC  = 3'd5;
    localparam logic [2:0] MM_WR   = 3'd6;
    localparam logic [2:0] MM_DONE = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = MM_IDLE,
        ST_RD_A = MM_RD_A,
        ST_WT_A = MM_WT_A,
        ST_RD_B = MM_RD_B,
        ST_WT_B = MM_WT_B,
        ST_MAC  = MM_MAC,
        ST_WR   = MM_WR,
        ST_DONE = MM_DONE
    } mm_state_t;

    // Byte distance between consecutive 32-bit matrix elements.
    localparam int unsigned MM_STRIDE = 4;

    // ALU control code decoded in EX to launch the sequencer.
    localparam logic [5:0] ALU_MATRIX_MUL = 6'h1a;

    // Which operand address the generator should produce.
    typedef enum logic [1:0] {
        SEL_A = 2'd0,
        SEL_B = 2'd1,
        SEL_C = 2'd2
    } mm_sel_t;

endpackage

// File: rtl/mm_addr_gen.sv
// Combinational element address generator for A (i,k), B (k,j) and C (i,j) of row-major NxN matrices.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs, all arithmetic wraps modulo 2^AW.
module mm_addr_gen
    import mm_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 32
) (
    input  logic [3:0]    i_i,
    input  logic [3:0]    i_j,
    input  logic [3:0]    i_k,
    input  mm_sel_t       i_sel,
    input  logic [AW-1:0] i_a_base,
    input  logic [AW-1:0] i_b_base,
    input  logic [AW-1:0] i_c_base,
    output logic [AW-1:0] o_addr
);

    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_idx;

    // Pick row/column/base for the selected matrix, then base + stride*(row*N + col).
    always_comb begin
        w_row  = '0;
        w_col  = '0;
        w_base = '0;
        case (i_sel)
            SEL_A: begin
                w_row  = AW'(i_i);
                w_col  = AW'(i_k);
                w_base = i_a_base;
            end
            SEL_B: begin
                w_row  = AW'(i_k);
                w_col  = AW'(i_j);
                w_base = i_b_base;
            end
            default: begin
                w_row  = AW'(i_i);
                w_col  = AW'(i_j);
                w_base = i_c_base;
            end
        endcase
        w_idx  = w_row * AW'(N) + w_col;
        o_addr = w_base + w_idx * AW'(MM_STRIDE);
    end

endmodule

// File: rtl/mm_seq.sv
// MATRIX_MUL sequencer: C = A x B over one memory port, stalling EX via busy; optional cycle counter under MM_CYCLE_CNT_EN.
// Latency: 5 cycles per k, 5N+1 per element with zero-wait memory; done pulses N^2*(5N+1)+1 cycles after start accept.
// Backpressure: holds mem_req/addr/we/wdata stable until mem_gnt; one read outstanding; stray mem_rvalid ignored.
module mm_seq
    import mm_seq_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] c_base,
    output logic          busy,
    output logic          done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
`ifdef MM_CYCLE_CNT_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    localparam logic [3:0] LAST = 4'(N - 1);

    mm_state_t     r_state;
    mm_state_t     w_next;
    mm_sel_t       w_sel;
    logic [3:0]    r_i;
    logic [3:0]    r_j;
    logic [3:0]    r_k;
    logic [31:0]   r_acc;
    logic [31:0]   r_opa;
    logic [31:0]   r_opb;
    logic [AW-1:0] r_a_base;
    logic [AW-1:0] r_b_base;
    logic [AW-1:0] r_c_base;
    logic          r_busy;
    logic [AW-1:0] w_addr;

    mm_addr_gen #(
        .N  (N),
        .AW (AW)
    ) u_addr_gen (
        .i_i      (r_i),
        .i_j      (r_j),
        .i_k      (r_k),
        .i_sel    (w_sel),
        .i_a_base (r_a_base),
        .i_b_base (r_b_base),
        .i_c_base (r_c_base),
        .o_addr   (w_addr)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and memory handshake outputs; outputs are state-decoded so reset clears them at once.
    always_comb begin
        w_next  = r_state;
        w_sel   = SEL_C;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        done    = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RD_A;
            ST_RD_A: begin
                mem_req = 1'b1;
                w_sel   = SEL_A;
                if (mem_gnt) w_next = ST_WT_A;
            end
            ST_WT_A: if (mem_rvalid) w_next = ST_RD_B;
            ST_RD_B: begin
                mem_req = 1'b1;
                w_sel   = SEL_B;
                if (mem_gnt) w_next = ST_WT_B;
            end
            ST_WT_B: if (mem_rvalid) w_next = ST_MAC;
            ST_MAC:  w_next = (r_k == LAST) ? ST_WR : ST_RD_A;
            ST_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_gnt) w_next = (r_i == LAST && r_j == LAST) ? ST_DONE : ST_RD_A;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign mem_addr  = mem_req ? w_addr : '0;
    assign mem_wdata = mem_we ? r_acc : '0;
    assign busy      = r_busy;

    // Busy rises the cycle after an accepted start and stays up through the DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_busy <= 1'b0;
        else if (r_state == ST_IDLE && start) r_busy <= 1'b1;
        else if (r_state == ST_DONE)          r_busy <= 1'b0;
    end

    // Loop indices, operand capture and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) begin
                    r_a_base <= a_base;
                    r_b_base <= b_base;
                    r_c_base <= c_base;
                    r_i      <= '0;
                    r_j      <= '0;
                    r_k      <= '0;
                    r_acc    <= '0;
                end
                ST_WT_A: if (mem_rvalid) r_opa <= mem_rdata;
                ST_WT_B: if (mem_rvalid) r_opb <= mem_rdata;
                ST_MAC: begin
                    r_acc <= r_acc + r_opa * r_opb;
                    if (r_k != LAST) r_k <= r_k + 4'd1;
                end
                ST_WR: if (mem_gnt) begin
                    r_acc <= '0;
                    r_k   <= '0;
                    if (r_j == LAST) begin
                        r_j <= '0;
                        r_i <= (r_i == LAST) ? 4'd0 : r_i + 4'd1;
                    end else begin
                        r_j <= r_j + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MM_CYCLE_CNT_EN
    logic [31:0] r_cycle_cnt;

    // Counts busy cycles of the current operation; cleared on accept, held after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_cycle_cnt <= '0;
        else if (r_state == ST_IDLE && start) r_cycle_cnt <= '0;
        else if (r_busy)                      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    assign cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_mm_seq.sv
// Bench for mm_seq with N=2: memory responder with programmable grant delay, write scoreboard, handshake monitor.
// Latency: checks done/busy timing against hand-derived cycle counts.
// Backpressure: grant stalls and stray rvalid pulses are injected by the responder.
module tb_mm_seq;

    localparam int          N      = 2;
    localparam int          AW     = 32;
    localparam logic [31:0] A_BASE = 32'h100;
    localparam logic [31:0] B_BASE = 32'h200;
    localparam logic [31:0] C_BASE = 32'h300;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a_base, b_base, c_base;
    logic        busy, done, mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MM_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    mm_seq #(.N(N), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_base     (a_base),
        .b_base     (b_base),
        .c_base     (c_base),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef MM_CYCLE_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory responder: grant after gnt_delay stalled cycles, read data one cycle after grant.
    logic [31:0] mem [256];
    int          gnt_delay = 0;
    int          stall     = 0;
    bit          spur_en   = 1'b0;

    assign mem_gnt = mem_req && (stall >= gnt_delay);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            stall      <= 0;
        end else if (mem_req && mem_gnt) begin
            stall      <= 0;
            mem_rvalid <= !mem_we;
            mem_rdata  <= mem_we ? 32'h0 : mem[mem_addr[9:2]];
        end else begin
            stall      <= mem_req ? stall + 1 : 0;
            mem_rvalid <= spur_en;
            mem_rdata  <= 32'hdead_beef;
        end
    end

    // Scoreboard of expected C writes.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    int          busy_cyc = 0;
    int          done_cnt = 0;
    int          req_cnt  = 0;
    logic        pend     = 1'b0;
    logic        p_we;
    logic [31:0] p_addr, p_wdata;

    // Monitor: pops expected writes on granted writes and checks request stability during stalls.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (busy)    busy_cyc++;
            if (done)    done_cnt++;
            if (mem_req) req_cnt++;
            if (pend) begin
                if (!mem_req) chk(1'b0, "req_dropped_without_gnt", 32'd0, 32'd1);
                else begin
                    chk(mem_addr == p_addr, "stall_addr_stable", mem_addr, p_addr);
                    chk(mem_we == p_we && mem_wdata == p_wdata, "stall_wdata_stable", mem_wdata, p_wdata);
                end
            end
            pend    = mem_req && !mem_gnt;
            p_addr  = mem_addr;
            p_we    = mem_we;
            p_wdata = mem_wdata;
            if (mem_req && mem_we && mem_gnt) begin
                if (exp_q.size() == 0) chk(1'b0, "unexpected_write", mem_addr, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk(mem_addr == e.addr, "wr_addr", mem_addr, e.addr);
                    chk(mem_wdata == e.data, "wr_data", mem_wdata, e.data);
                end
            end
        end
    end

    task automatic load(input logic [127:0] av, input logic [127:0] bv);
        for (int e = 0; e < 4; e++) begin
            mem[64 + e]  = av[127 - 32*e -: 32];
            mem[128 + e] = bv[127 - 32*e -: 32];
        end
    endtask

    task automatic push_exp(input logic [127:0] cv, input int cnt);
        wr_t w;
        for (int e = 0; e < cnt; e++) begin
            w.addr = C_BASE + 32'(4*e);
            w.data = cv[127 - 32*e -: 32];
            exp_q.push_back(w);
        end
    endtask

    // Launches one operation and checks done latency, busy length and done-pulse count.
    task automatic run_op(input int exp_lat, input string nm, input bit mid_start);
        int s, t, b0, d0;
        @(negedge clk);
        b0 = busy_cyc;
        d0 = done_cnt;
        a_base = A_BASE; b_base = B_BASE; c_base = C_BASE;
        start  = 1'b1;
        s      = cyc;
        @(negedge clk);
        start  = 1'b0;
`ifdef MM_CYCLE_CNT_EN
        chk(cycle_cnt == 32'd0, {nm, "_cnt_restart"}, cycle_cnt, 32'd0);
`endif
        t = 0;
        while (!done && t < 3000) begin
            if (mid_start && cyc == s + 10) begin
                start = 1'b1; a_base = 32'h0; b_base = 32'h0; c_base = 32'h3f0;
            end else begin
                start = 1'b0; a_base = A_BASE; b_base = B_BASE; c_base = C_BASE;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        if (!done) chk(1'b0, {nm, "_done_timeout"}, 32'(t), 32'(exp_lat));
        else       chk(cyc - s == exp_lat, {nm, "_done_latency"}, 32'(cyc - s), 32'(exp_lat));
        repeat (3) @(negedge clk);
        chk(busy_cyc - b0 == exp_lat, {nm, "_busy_cycles"}, 32'(busy_cyc - b0), 32'(exp_lat));
        chk(done_cnt - d0 == 1, {nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        chk(exp_q.size() == 0, {nm, "_writes_left"}, 32'(exp_q.size()), 32'd0);
`ifdef MM_CYCLE_CNT_EN
        chk(cycle_cnt == 32'(exp_lat), {nm, "_cycle_cnt"}, cycle_cnt, 32'(exp_lat));
`endif
    endtask

    initial begin
        int s, r0;
        for (int a = 0; a < 256; a++) mem[a] = 32'h0;
        rst = 1'b1; start = 1'b0;
        a_base = '0; b_base = '0; c_base = '0;
        repeat (3) @(negedge clk);
        chk({busy, done, mem_req, mem_we} == 4'b0, "reset_ctrl", 32'({busy, done, mem_req, mem_we}), 32'd0);
        chk(mem_addr == 32'd0, "reset_addr", mem_addr, 32'd0);
        chk(mem_wdata == 32'd0, "reset_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A=[1 2;3 4] x identity, zero-wait: C=A, done after 45 cycles.
        load({32'd1, 32'd2, 32'd3, 32'd4}, {32'd1, 32'd0, 32'd0, 32'd1});
        push_exp({32'd1, 32'd2, 32'd3, 32'd4}, 4);
        run_op(45, "ident", 1'b0);
`ifdef MM_CYCLE_CNT_EN
        repeat (5) @(negedge clk);
        chk(cycle_cnt == 32'd45, "cnt_hold", cycle_cnt, 32'd45);
`endif

        // A=[1 2;3 4] x [5 6;7 8], every grant stalled 3 cycles: 5 requests/element add 15 cycles.
        load({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8});
        push_exp({32'd19, 32'd22, 32'd43, 32'd50}, 4);
        gnt_delay = 3;
        run_op(105, "stall", 1'b0);
        gnt_delay = 0;

        // Overflow: (0x80000001)^2 mod 2^32 = 1, summed over N=2 gives 2.
        load({4{32'h8000_0001}}, {4{32'h8000_0001}});
        push_exp({32'd2, 32'd2, 32'd2, 32'd2}, 4);
        run_op(45, "wrap", 1'b0);

        // Second start mid-operation and stray rvalid pulses: results and timing unchanged.
        load({32'd1, 32'd2, 32'd3, 32'd4}, {32'd5, 32'd6, 32'd7, 32'd8});
        push_exp({32'd19, 32'd22, 32'd43, 32'd50}, 4);
        spur_en = 1'b1;
        run_op(45, "restart_spur", 1'b1);
        spur_en = 1'b0;

        // Reset in the third MAC (cycle start+16): only C[0][0]=19 has been written.
        push_exp({32'd19, 32'd0, 32'd0, 32'd0}, 1);
        @(negedge clk);
        a_base = A_BASE; b_base = B_BASE; c_base = C_BASE;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 16) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({busy, done, mem_req, mem_we} == 4'b0, "midrst_ctrl", 32'({busy, done, mem_req, mem_we}), 32'd0);
        chk(mem_addr == 32'd0 && mem_wdata == 32'd0, "midrst_bus", mem_addr | mem_wdata, 32'd0);
        chk(exp_q.size() == 0, "midrst_first_write", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        r0 = req_cnt;
        repeat (20) @(negedge clk);
        chk(req_cnt == r0, "post_rst_no_req", 32'(req_cnt - r0), 32'd0);
        chk(busy == 1'b0, "post_rst_busy", 32'(busy), 32'd0);
`ifdef MM_CYCLE_CNT_EN
        chk(cycle_cnt == 32'd0, "post_rst_cnt", cycle_cnt, 32'd0);
`endif

        // Operation after reset recovery still produces the right product.
        push_exp({32'd19, 32'd22, 32'd43, 32'd50}, 4);
        run_op(45, "after_rst", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
